// File: rtl/bcd_display_pkg.sv
// Shared definitions for the multiplexed BCD display scanner: segment patterns,
// scan states and the digit-index width helper.
package bcd_display_pkg;

   // Active-high segment patterns, bit 6 = A ... bit 0 = G.
   localparam logic [6:0] SEG_0     = 7'h7E;
   localparam logic [6:0] SEG_1     = 7'h30;
   localparam logic [6:0] SEG_2     = 7'h6D;
   localparam logic [6:0] SEG_3     = 7'h79;
   localparam logic [6:0] SEG_4     = 7'h33;
   localparam logic [6:0] SEG_5     = 7'h5B;
   localparam logic [6:0] SEG_6     = 7'h5F;
   localparam logic [6:0] SEG_7     = 7'h70;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h7B;
   localparam logic [6:0] SEG_DASH  = 7'h01;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic {
      S_GAP = 1'b0,
      S_ON  = 1'b1
   } scan_state_t;

   function automatic int index_width(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational nibble-to-segment decoder producing an active-high ABCDEFG
// pattern; non-decimal nibbles show a dash and the blank flag wins over both.
module seven_seg_decode
   import bcd_display_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] pattern
);

   always_comb begin
      // NOTE: assigning a default before any branch keeps every path driven, so no latch is inferred.
      pattern = SEG_DASH;
      if (blank) begin
         pattern = SEG_BLANK;
      end else begin
         case (nibble)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// Filters a settling packed-BCD value and time-multiplexes it onto a 7-segment
// display with a dark gap between slots. Optional: BCD_SCAN_LEADING_ZERO_BLANK_EN.
module bcd_display_scanner
   import bcd_display_pkg::*;
#(
   parameter int DECIMAL_DIGITS = 2,
   parameter int ON_CYCLES      = 25000,
   parameter int GAP_CYCLES     = 250,
   parameter int STABLE_CYCLES  = 16,
   parameter bit ACTIVE_LOW     = 1'b1
)(
   input  logic                                     i_Clock,
   input  logic                                     i_Reset,
   input  logic [DECIMAL_DIGITS*4-1:0]              i_BCD,
   output logic [6:0]                               o_Segments,
   output logic [DECIMAL_DIGITS-1:0]                o_Digit_Enable,
   output logic [index_width(DECIMAL_DIGITS)-1:0]   o_Digit_Index,
   output logic                                     o_Stable
);

   localparam int BCD_W    = DECIMAL_DIGITS * 4;
   localparam int IDX_W    = index_width(DECIMAL_DIGITS);
   localparam int STB_W    = $clog2(STABLE_CYCLES + 1);
   localparam int SCAN_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
   localparam int SCAN_W   = $clog2(SCAN_MAX + 1);

   localparam logic [STB_W-1:0]  STB_MAX  = STB_W'(STABLE_CYCLES);
   localparam logic [SCAN_W-1:0] ON_LAST  = SCAN_W'(ON_CYCLES - 1);
   localparam logic [SCAN_W-1:0] GAP_LAST = SCAN_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DECIMAL_DIGITS - 1);
   // With no gap the scanner lives permanently in S_ON.
   localparam scan_state_t SLOT_START = (GAP_CYCLES == 0) ? S_ON : S_GAP;

   logic [BCD_W-1:0]          prev_bcd;
   logic [BCD_W-1:0]          shown_bcd;
   logic [STB_W-1:0]          stable_cnt;
   scan_state_t               state;
   logic [SCAN_W-1:0]         scan_cnt;
   logic [IDX_W-1:0]          index;
   logic [3:0]                nibble;
   logic                      blank;
   logic [6:0]                pattern;
   logic [DECIMAL_DIGITS-1:0] enable_high;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         prev_bcd   <= '0;
         shown_bcd  <= '0;
         stable_cnt <= '0;
      end else begin
         // NOTE: non-blocking updates let the compare below see last cycle's prev_bcd.
         prev_bcd <= i_BCD;
         if (i_BCD != prev_bcd) begin
            stable_cnt <= '0;
         end else if (stable_cnt != STB_MAX) begin
            stable_cnt <= stable_cnt + 1'b1;
            if (stable_cnt == STB_MAX - 1'b1)
               shown_bcd <= i_BCD;
         end
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state    <= SLOT_START;
         scan_cnt <= '0;
         index    <= '0;
      end else begin
         case (state)
            S_GAP: begin
               if (scan_cnt == GAP_LAST) begin
                  state    <= S_ON;
                  scan_cnt <= '0;
               end else begin
                  scan_cnt <= scan_cnt + 1'b1;
               end
            end
            S_ON: begin
               if (scan_cnt == ON_LAST) begin
                  state    <= SLOT_START;
                  scan_cnt <= '0;
                  index    <= (index == IDX_LAST) ? '0 : index + 1'b1;
               end else begin
                  scan_cnt <= scan_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      nibble = '0;
      for (int d = 0; d < DECIMAL_DIGITS; d++)
         if (IDX_W'(d) == index)
            nibble = shown_bcd[d*4 +: 4];
   end

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
   logic upper_zero;

   // A digit is blank when it and every digit above it are zero; digit 0 never blanks.
   always_comb begin
      upper_zero = 1'b1;
      for (int d = 0; d < DECIMAL_DIGITS; d++)
         if (d >= int'(index) && shown_bcd[d*4 +: 4] != 4'd0)
            upper_zero = 1'b0;
      blank = (index != '0) && upper_zero;
   end
`else
   assign blank = 1'b0;
`endif

   seven_seg_decode u_decode (
      .nibble  (nibble),
      .blank   (blank),
      .pattern (pattern)
   );

   always_comb begin
      enable_high = '0;
      for (int d = 0; d < DECIMAL_DIGITS; d++)
         enable_high[d] = (state == S_ON) && (IDX_W'(d) == index);
   end

   assign o_Digit_Enable = ACTIVE_LOW ? ~enable_high : enable_high;
   assign o_Segments     = ACTIVE_LOW ? ~pattern : pattern;
   assign o_Digit_Index  = index;
   assign o_Stable       = (shown_bcd == i_BCD);

endmodule
